// File: rtl/cnn_mem_pkg.sv
// Shared definitions for the CNN memory-side streaming blocks.
// Read-sequencer state encoding, RAM timing and default bus widths.
package cnn_mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain
  } rd_state_e;

  // blk_mem_gen read port: douta is valid this many cycles after ena.
  localparam int unsigned RamRdLatency = 1;

  localparam int unsigned DefaultAddrW = 5;
  localparam int unsigned DefaultDataW = 8;

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with first-word-fall-through output and a registered count.
// A push while full is accepted only if a pop happens in the same cycle.
module stream_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 9,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic            pop_i,
  output logic [Width-1:0] rdata_o,
  output logic            valid_o,
  output logic [CntW-1:0] count_o
);

  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             full, push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : PtrW'(p + 1);
  endfunction

  // Output is forced to zero while empty so the stream bus is quiet between bursts.
  always_comb begin
    full    = (count_q == CntW'(Depth));
    valid_o = (count_q != '0);
    pop_ok  = pop_i && valid_o;
    push_ok = push_i && (!full || pop_ok);
    rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
    count_o = count_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_ok && !pop_ok) begin
        count_q <= CntW'(count_q + 1);
      end else if (pop_ok && !push_ok) begin
        count_q <= CntW'(count_q - 1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Sweeps an address range of a single-port block RAM and presents the words as a
// valid/ready stream; reads are only issued when the output FIFO has a free slot.
module bram_stream_reader
  import cnn_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefaultAddrW,
  parameter int unsigned DATA_W     = DefaultDataW,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  rd_state_e               state_q, state_d;
  logic                    done_q, done_d;
  logic [ADDR_W-1:0]       cur_q, last_addr_q;
  logic [ADDR_W:0]         remaining_q;
  logic [RamRdLatency-1:0] rd_vld_q, rd_last_q;
  logic [CntW-1:0]         fifo_count;
  logic [DATA_W:0]         fifo_rdata;
  logic                    fifo_valid;
  logic                    issue, last_issue, credit_ok, pop;
  int unsigned             outstanding;

  // Credit check uses registered occupancy only; a pop this cycle frees a slot next cycle.
  always_comb begin
    outstanding = 32'(fifo_count);
    for (int i = 0; i < RamRdLatency; i++) begin
      outstanding += 32'(rd_vld_q[i]);
    end
    credit_ok  = (outstanding < FIFO_DEPTH);
    last_issue = (remaining_q == (ADDR_W + 1)'(1));
    pop        = fifo_valid && out_ready;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len == '0) done_d = 1'b1;
          else           state_d = StFetch;
        end
      end
      StFetch: begin
        if (issue && last_issue) state_d = StDrain;
      end
      StDrain: begin
        if (pop && out_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    issue    = (state_q == StFetch) && credit_ok;
    busy     = (state_q != StIdle);
    done     = done_q;
    mem_en   = issue;
    mem_addr = issue ? cur_q : last_addr_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_q       <= '0;
      last_addr_q <= '0;
      remaining_q <= '0;
      rd_vld_q    <= '0;
      rd_last_q   <= '0;
    end else begin
      if ((state_q == StIdle) && start) begin
        cur_q       <= base_addr;
        remaining_q <= len;
      end else if (issue) begin
        cur_q       <= ADDR_W'(cur_q + 1);
        remaining_q <= (ADDR_W + 1)'(remaining_q - 1);
        last_addr_q <= cur_q;
      end
      // Tracks reads in the RAM pipeline so returning data is tagged with its last flag.
      rd_vld_q[0]  <= issue;
      rd_last_q[0] <= issue && last_issue;
      for (int i = 1; i < RamRdLatency; i++) begin
        rd_vld_q[i]  <= rd_vld_q[i-1];
        rd_last_q[i] <= rd_last_q[i-1];
      end
    end
  end

  stream_fifo #(
    .Depth(FIFO_DEPTH),
    .Width(DATA_W + 1)
  ) u_fifo (
    .clk_i  (clock),
    .rst_i  (reset),
    .push_i (rd_vld_q[RamRdLatency-1]),
    .wdata_i({rd_last_q[RamRdLatency-1], mem_dout}),
    .pop_i  (pop),
    .rdata_o(fifo_rdata),
    .valid_o(fifo_valid),
    .count_o(fifo_count)
  );

  assign out_valid = fifo_valid;
  assign out_data  = fifo_rdata[DATA_W-1:0];
  assign out_last  = fifo_rdata[DATA_W];

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader: a behavioural RAM, a start-acceptance model
// that queues expected addresses/words, and a negedge monitor that checks the DUT.
module tb_bram_stream_reader;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;
  localparam int unsigned FD = 4;
  localparam int unsigned NW = 1 << AW;

  logic          clock     = 1'b0;
  logic          reset     = 1'b1;
  logic          start     = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len       = '0;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout  = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          busy;
  logic          done;

  bram_stream_reader #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .FIFO_DEPTH(FD)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .mem_dout (mem_dout),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] ram [NW];
  always @(posedge clock) if (mem_en) mem_dout <= ram[mem_addr];

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Scoreboard state
  logic [DW:0]   exp_q[$];
  logic [AW-1:0] addr_q[$];
  bit            model_busy = 0;
  bit            due_next   = 0;
  bit            due_now    = 0;
  bit            stall_prev = 0;
  logic [DW:0]   prev_w     = '0;
  int unsigned   issued     = 0;
  int unsigned   hs         = 0;
  logic [AW-1:0] a;
  logic [DW:0]   w;

  always @(negedge clock) begin
    if (reset) begin
      chk("reset_outputs",
          32'({mem_en, mem_addr, out_data, out_valid, out_last, busy, done}), 32'd0);
      exp_q.delete();
      addr_q.delete();
      model_busy = 0;
      due_next   = 0;
      due_now    = 0;
      stall_prev = 0;
      issued     = 0;
      hs         = 0;
    end else begin
      due_now  = due_next;
      due_next = 0;
      chk("busy", 32'(busy), 32'(model_busy));
      if (done || due_now) chk("done", 32'(done), 32'(due_now));
      if (stall_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_word", 32'({out_last, out_data}), 32'(prev_w));
      end
      if (addr_q.size() == 0) begin
        chk("idle_mem_en", 32'(mem_en), 32'd0);
      end else if (mem_en) begin
        chk("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
        chk("credit", 32'((issued - hs) < FD), 32'd1);
        issued++;
      end
      // Start is sampled at the next rising edge; accepted only when not busy.
      if (start && !model_busy) begin
        if (len == '0) begin
          due_next = 1;
        end else begin
          model_busy = 1;
          for (int k = 0; k < int'(len); k++) begin
            a = AW'(base_addr + AW'(k));
            addr_q.push_back(a);
            exp_q.push_back({(k == int'(len) - 1), ram[a]});
          end
        end
      end
      if (exp_q.size() == 0) begin
        chk("idle_valid", 32'(out_valid), 32'd0);
      end else if (out_valid && out_ready) begin
        w = exp_q.pop_front();
        chk("stream_word", 32'({out_last, out_data}), 32'(w));
        hs++;
        if (exp_q.size() == 0) begin
          model_busy = 0;
          due_next   = 1;
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_w     = {out_last, out_data};
    end
  end

  // Ready pattern: 0 = always ready, 1 = alternating, 2 = random, 3 = held low.
  int rmode = 0;
  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        2:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic start_burst(input logic [AW-1:0] b, input logic [AW:0] l);
    @(posedge clock);
    #1;
    base_addr = b;
    len       = l;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clock);
      #1;
      ok = (exp_q.size() == 0) && !model_busy && !due_next;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: burst still open after %0d cycles, %0d words pending",
               budget, exp_q.size());
    end
  endtask

  task automatic fill_identity();
    for (int i = 0; i < NW; i++) ram[i] = DW'(i);
  endtask

  int unsigned issued0, hs0;

  initial begin
    fill_identity();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Full sweep with ready held: first word in cycle 3, done in cycle 35.
    rmode = 0;
    start_burst(5'd0, 6'd32);
    @(negedge clock);
    chk("c1_mem_en", 32'(mem_en), 32'd1);
    chk("c1_mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clock);
    chk("c2_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    chk("c3_valid", 32'(out_valid), 32'd1);
    chk("c3_data", 32'(out_data), 32'd0);
    repeat (32) @(negedge clock);
    chk("c35_done", 32'(done), 32'd1);
    chk("c35_busy", 32'(busy), 32'd0);
    wait_idle(200);

    // Address wrap.
    start_burst(5'd30, 6'd4);
    wait_idle(200);

    // Alternating backpressure.
    rmode = 1;
    start_burst(5'd9, 6'd16);
    wait_idle(400);

    // Consumer stalled for 20 cycles: only FD reads may be issued.
    rmode   = 3;
    issued0 = issued;
    start_burst(5'd0, 6'd10);
    repeat (20) @(negedge clock);
    #1;
    chk("stall_reads", issued - issued0, FD);
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_data", 32'(out_data), 32'd0);
    rmode = 0;
    wait_idle(200);

    // Zero-length burst.
    start_burst(5'd3, 6'd0);
    @(negedge clock);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    chk("len0_done_clr", 32'(done), 32'd0);
    wait_idle(50);

    // Randomised bursts on random RAM contents.
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < NW; i++) ram[i] = DW'($urandom);
      rmode = int'($urandom_range(0, 2));
      start_burst(AW'($urandom_range(0, NW - 1)),
                  ($urandom_range(0, 7) == 0) ? '0 : (AW + 1)'($urandom_range(1, NW)));
      wait_idle(3000);
    end

    // Start held high with changing operands: ignored while busy, taken in done cycle.
    rmode = 2;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #1;
      start     = 1'b1;
      base_addr = AW'($urandom_range(0, NW - 1));
      len       = (AW + 1)'($urandom_range(0, 8));
    end
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_idle(3000);

    // Ignored start mid-burst, then reset after the 10th handshake.
    fill_identity();
    rmode = 0;
    hs0   = hs;
    start_burst(5'd0, 6'd20);
    @(posedge clock);
    #1;
    start     = 1'b1;
    base_addr = 5'd7;
    len       = 6'd5;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int i = 0; i < 200 && hs < hs0 + 10; i++) begin
      @(negedge clock);
      #1;
    end
    chk("ten_handshakes", 32'(hs >= hs0 + 10), 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs",
        32'({mem_en, mem_addr, out_data, out_valid, out_last, busy, done}), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    start_burst(5'd0, 6'd3);
    wait_idle(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors",
             checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Sequencer that sweeps a block of addresses in a single-port block RAM (`blk_mem_gen_*`: 1-cycle read latency, ena/wea/addra/douta) and presents the read words as a valid/ready byte stream to the next CNN stage (convolution/MAC input). It sits directly downstream of the weight/image RAMs and owns their read port. Backpressure is absorbed by a small credit-controlled FIFO so no read data is ever dropped.

## Interface
- `ADDR_W`, 5, RAM address width
- `DATA_W`, 8, RAM data width
- `FIFO_DEPTH`, 4, output buffer entries (must be ≥ 3)

- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  request a burst; sampled only when `busy`=0
- `base_addr`  in  ADDR_W  first address of burst, captured with `start`
- `len`  in  ADDR_W+1  word count, 0..2^ADDR_W, captured with `start`
- `mem_en`  out  1  RAM ena; high only in cycles that issue a read
- `mem_addr`  out  ADDR_W  RAM addra
- `mem_dout`  in  DATA_W  RAM douta, valid one cycle after `mem_en`
- `out_data`  out  DATA_W  stream data
- `out_valid`  out  1  stream valid
- `out_ready`  in  1  stream ready from consumer
- `out_last`  out  1  high with final word of burst
- `busy`  out  1  burst in progress
- `done`  out  1  one-cycle pulse at burst completion

## Operation
- FSM states: IDLE, FETCH, DRAIN.
- IDLE: `start`=1 latches `base_addr`, `len`; len=0 → `done` pulse next cycle, stay IDLE, no stream output; else → FETCH.
- FETCH: issue read (`mem_en`=1, `mem_addr`=cur) when `fifo_count + inflight < FIFO_DEPTH` (registered values, no pop look-ahead). cur increments modulo 2^ADDR_W (30,31,0,1…). After len-th issue → DRAIN.
- DRAIN: wait until FIFO empty and no read in flight, last word handshaken → IDLE with `done`=1.
- Each returned word enters FIFO with a last flag (index len-1).
- Stream rules: `out_data`/`out_last` stable while `out_valid`=1 and `out_ready`=0; handshake = valid & ready; `out_valid` never deasserts without handshake.
- `start` while `busy`=1 ignored. `start` in the `done` cycle is accepted.
- `mem_addr` holds last issued value when `mem_en`=0; `wea` is not driven by this block (tie 0 at top).
- Reset (any time, incl. mid-burst): all state cleared immediately, FIFO emptied, in-flight read discarded, returns to IDLE.

## Timing
- Reset values: `mem_en`=0, `mem_addr`=0, `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0.
- Start sampled at edge E0 → first `mem_en` in cycle 1 → data on `mem_dout` cycle 2, written to FIFO at end of cycle 2 → `out_valid`=1 in cycle 3 (first-word latency 3).
- With `out_ready` held 1: one word per cycle, no bubbles; len=N completes last handshake in cycle N+2.
- `busy`=1 from cycle 1 through cycle of last handshake; `done`=1 (and `busy`=0) the following cycle.
- With `out_ready`=0: at most FIFO_DEPTH reads outstanding+buffered; `mem_en` stops.

## Structure
- Shared package `cnn_mem_pkg`: FSM state encoding, RAM read latency constant (1), default ADDR_W/DATA_W.
- One sub-module: `stream_fifo` (synchronous, FIFO_DEPTH × (DATA_W+1), registered count, first-word-fall-through output, simultaneous push/pop at full allowed only when pop occurs).
- Top: FSM, address/issue counters, inflight flag, credit compare.

## Test plan
- RAM mem[i]=i, base=0, len=32, ready=1 → out_data 0..31 in cycles 3..34, out_last only on 31, done in cycle 35.
- base=30, len=4 → mem_addr 30,31,0,1; out_data 30,31,0,1; last on 1.
- out_ready alternating 1/0 for len=16 → 16 words in order, no duplicates/losses, fifo_count+inflight ≤ 4 every cycle.
- out_ready held 0 for 20 cycles after start, len=10 → exactly 4 `mem_en` pulses, out_data=0 held stable, then words 0..9 in order on release.
- len=0 → done=1 in cycle 1, out_valid never asserted, busy stays 0.
- start pulsed while busy ignored; reset asserted after 10th handshake → all outputs 0 same cycle, next start with base=0 len=3 streams 0,1,2.
